sha_core_arbiter: RTL and testbench

// - Shares one shapipe SHA-256 single-block core among NREQ requesters, each offering a pre-padded 512-bit block.
// - Round-robin grant; latches the granted block; sequences the core's sync reset; waits for the core's ready; returns digest tagged with requester id.
// - Sits between the message-padding front ends and the shapipe instance.

---
 rtl/sha_core_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sha_core_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter sharing one single-block SHA-256 core among NREQ requesters.
// Optional wait-for-ready timeout enabled by defining SHA_ARB_TIMEOUT_EN.
module sha_core_arbiter #(
  parameter int NREQ        = 4,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 127,
  localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*512-1:0] req_msg,
  output logic [NREQ-1:0]   req_grant,
  output logic              core_reset,
  output logic [511:0]      core_msg,
  input  logic              core_ready,
  input  logic [255:0]      core_hash,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [255:0]      rsp_digest,
  output logic              rsp_err,
  output logic              busy
);
  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             core_reset_q, core_reset_d;
  logic [511:0]     core_msg_q, core_msg_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [255:0]     rsp_digest_q, rsp_digest_d;
  logic             busy_q, busy_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx, nxt_ptr;
  logic [511:0]     sel_msg;

`ifdef SHA_ARB_TIMEOUT_EN
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT_CYC - 1));
  assign rsp_err     = rsp_err_q;
`else
  logic             unused_cfg;
  assign unused_cfg  = ^8'(TIMEOUT_CYC);
  assign rsp_err     = 1'b0;
`endif

  // Cyclic search from rr_ptr: walk downward so the nearest candidate wins last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    sel_msg = '0;
    for (int i = 0; i < NREQ; i++)
      if (IDW'(i) == gnt_idx) sel_msg = req_msg[512*i +: 512];
    nxt_ptr = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
  end

  assign req_grant = (!reset && state_q == IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    core_reset_d = core_reset_q;
    core_msg_d   = core_msg_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_digest_d = rsp_digest_q;
    rst_cnt_d    = rst_cnt_q;
`ifdef SHA_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: if (gnt_found) begin
        core_msg_d = sel_msg;
        rsp_id_d   = gnt_idx;
        rr_ptr_d   = nxt_ptr;
        rst_cnt_d  = '0;
        state_d    = LOAD;
      end
      LOAD: if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
        core_reset_d = 1'b0;
        state_d      = WAIT_LOW;
`ifdef SHA_ARB_TIMEOUT_EN
        wait_cnt_d   = '0;
`endif
      end else begin
        rst_cnt_d = rst_cnt_q + 1'b1;
      end
      // The core's ready trails its reset, so a high left over from the last job is skipped.
      WAIT_LOW: if (!core_ready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (core_ready) begin
        rsp_digest_d = core_hash;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
`ifdef SHA_ARB_TIMEOUT_EN
        rsp_err_d    = 1'b0;
`endif
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d  = 1'b0;
        core_reset_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SHA_ARB_TIMEOUT_EN
    if ((state_q == WAIT_LOW || state_q == WAIT_HIGH) && state_d != RESP) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (timeout_hit) begin
        rsp_digest_d = '0;
        rsp_err_d    = 1'b1;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
    end
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      core_reset_q <= 1'b1;
      core_msg_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_digest_q <= '0;
      busy_q       <= 1'b0;
      rst_cnt_q    <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      core_reset_q <= core_reset_d;
      core_msg_q   <= core_msg_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_digest_q <= rsp_digest_d;
      busy_q       <= busy_d;
      rst_cnt_q    <= rst_cnt_d;
`ifdef SHA_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign core_reset = core_reset_q;
  assign core_msg   = core_msg_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_digest = rsp_digest_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_sha_core_arbiter.sv
// Bench for sha_core_arbiter: behavioural core stub, grant/response scoreboards fed by stimulus.
module tb_sha_core_arbiter;
`ifdef SHA_ARB_TIMEOUT_EN
  localparam int TB_TO = 10;
`else
  localparam int TB_TO = 127;
`endif
  localparam int NREQ = 4;
  localparam int LAT  = 6;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_B     = {{8{32'h12345678}}, {8{32'h0000FFFF}}};
  localparam logic [511:0] BLK_D     = {{8{32'hDEADBEEF}}, {8{32'h01020304}}};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] E_B     = {8{32'h1234A987}};
  localparam logic [255:0] E_D     = {8{32'hDFAFBDEB}};

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0][511:0] msgs;
  logic [NREQ*512-1:0] req_msg;
  logic [NREQ-1:0] req_grant;
  logic core_reset, core_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [511:0] core_msg;
  logic [255:0] core_hash, rsp_digest;
  logic [1:0] rsp_id;
  logic stub_dead;

  assign req_msg = msgs;
  always #5 clk = ~clk;

  sha_core_arbiter #(.NREQ(NREQ), .RST_CYC(2), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_msg(req_msg),
    .req_grant(req_grant), .core_reset(core_reset), .core_msg(core_msg),
    .core_ready(core_ready), .core_hash(core_hash), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_digest(rsp_digest),
    .rsp_err(rsp_err), .busy(busy));

  // Core stub: known digests for the two standard blocks, half-fold otherwise.
  function automatic logic [255:0] core_model(input logic [511:0] m);
    if (m == BLK_ABC)   return D_ABC;
    if (m == BLK_EMPTY) return D_EMPTY;
    return m[511:256] ^ m[255:0];
  endfunction

  logic [1:0] rst_sh;
  int scnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sh <= 2'b11; core_ready <= 1'b0; core_hash <= '0; scnt <= 0;
    end else begin
      rst_sh <= {rst_sh[0], core_reset};
      if (rst_sh[1]) begin
        core_ready <= 1'b0; scnt <= 0;
      end else if (!core_ready && !stub_dead) begin
        if (scnt == LAT) begin
          core_ready <= 1'b1; core_hash <= core_model(core_msg);
        end else scnt <= scnt + 1;
      end
    end
  end

  typedef struct packed { logic [1:0] id; logic [255:0] dig; logic err; } rsp_t;
  rsp_t rq[$];
  logic [3:0] gq[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (req_grant != 0) begin
        checks++;
        if (gq.size() == 0) begin
          errors++; $display("FAIL grant_unexpected got=%b", req_grant);
        end else begin
          logic [3:0] eg;
          eg = gq.pop_front();
          if (req_grant !== eg) begin errors++; $display("FAIL grant got=%b exp=%b", req_grant, eg); end
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL rsp_unexpected id=%0d", rsp_id);
        end else begin
          rsp_t e;
          e = rq.pop_front();
          if (rsp_id !== e.id || rsp_digest !== e.dig || rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp got id=%0d err=%b dig=%h exp id=%0d err=%b dig=%h",
                     rsp_id, rsp_err, rsp_digest, e.id, e.err, e.dig);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", nm, act, exp); end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_grant"}, 256'(req_grant), 256'h0);
    chk({nm, "_core_reset"}, 256'(core_reset), 256'h1);
    chk({nm, "_core_msg"}, core_msg[511:256] | core_msg[255:0], 256'h0);
    chk({nm, "_rsp_valid"}, 256'(rsp_valid), 256'h0);
    chk({nm, "_rsp_id"}, 256'(rsp_id), 256'h0);
    chk({nm, "_rsp_digest"}, rsp_digest, 256'h0);
    chk({nm, "_rsp_err"}, 256'(rsp_err), 256'h0);
    chk({nm, "_busy"}, 256'(busy), 256'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic issue(input logic [1:0] lane, input logic [511:0] blk,
                       input logic [255:0] dig, input logic err);
    msgs[lane] = blk;
    req_valid[lane] = 1'b1;
    gq.push_back(4'b0001 << lane);
    rq.push_back('{lane, dig, err});
  endtask

  task automatic wait_grant(input logic [1:0] lane);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_grant[lane] && n < 300);
    if (!req_grant[lane]) begin
      checks++; errors++; $display("FAIL grant_timeout lane=%0d", lane);
    end
    @(posedge clk); #1;
    req_valid[lane] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || busy) && n < 500) begin tick(1); n++; end
    chk("idle_drain", 256'(rq.size() + gq.size()), 256'h0);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; msgs = '0; rsp_ready = 1'b1; stub_dead = 1'b0;
    #1;
    chk_reset_vals("por");
    tick(2);
    reset = 1'b0;
    tick(1);

    // Single requests on lanes 0 and 2.
    issue(2'd0, BLK_ABC, D_ABC, 1'b0);
    wait_grant(2'd0);
    wait_idle();
    issue(2'd2, BLK_EMPTY, D_EMPTY, 1'b0);
    wait_grant(2'd2);
    wait_idle();

    // All four lanes contend from rr_ptr = 0; fifth job returns to lane 0.
    do_reset();
    issue(2'd0, BLK_ABC, D_ABC, 1'b0);
    issue(2'd1, BLK_B, E_B, 1'b0);
    issue(2'd2, BLK_EMPTY, D_EMPTY, 1'b0);
    issue(2'd3, BLK_D, E_D, 1'b0);
    wait_grant(2'd0);
    wait_grant(2'd1);
    wait_grant(2'd2);
    wait_grant(2'd3);
    issue(2'd0, BLK_EMPTY, D_EMPTY, 1'b0);
    wait_grant(2'd0);
    wait_idle();

    // Consumer stall with another request pending.
    rsp_ready = 1'b0;
    issue(2'd1, BLK_B, E_B, 1'b0);
    wait_grant(2'd1);
    issue(2'd3, BLK_D, E_D, 1'b0);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin tick(1); n++; end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stall_valid", 256'(rsp_valid), 256'h1);
      chk("stall_digest", rsp_digest, E_B);
      chk("stall_busy", 256'(busy), 256'h1);
      chk("stall_nogrant", 256'(req_grant), 256'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("grant_after_handshake", 256'(req_grant), 256'h8);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_idle();

    // Reset in WAIT_HIGH drops the job.
    msgs[2] = BLK_D;
    req_valid[2] = 1'b1;
    gq.push_back(4'b0100);
    wait_grant(2'd2);
    begin
      int n = 0;
      while (core_reset && n < 50) begin tick(1); n++; end
      chk("load_done", 256'(core_reset), 256'h0);
    end
    tick(4);
    reset = 1'b1;
    #1;
    chk_reset_vals("midjob");
    tick(2);
    reset = 1'b0;
    tick(1);
    issue(2'd1, BLK_ABC, D_ABC, 1'b0);
    wait_grant(2'd1);
    wait_idle();

`ifdef SHA_ARB_TIMEOUT_EN
    stub_dead = 1'b1;
    issue(2'd0, BLK_ABC, 256'h0, 1'b1);
    begin
      int n = 0;
      wait_grant(2'd0);
      n = 1;
      while (!rsp_valid && n < 40) begin tick(1); n++; end
      chk("timeout_latency_ok", 256'(n <= 10 + 2 + 2), 256'h1);
    end
    wait_idle();
    stub_dead = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
